// File: rtl/shift_u_seq_pkg.sv
// Purpose: shared mode encodings and FSM state type for the sequential shift unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_u_seq_pkg;

    // ALU_fun_SU encodings
    localparam logic [1:0] MODE_SRL = 2'b00;
    localparam logic [1:0] MODE_SLL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_u_step.sv
// Purpose: combinational single-position shifter (one step of SRL/SLL/SRA/ROL).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows input every cycle.
//
// Ports:
//   word      in  WIDTH  current working word
//   mode      in  2      shift mode (shift_u_seq_pkg MODE_*)
//   next_word out WIDTH  word after one step
//   out_bit   out 1      bit shifted or rotated out by this step
//
// Build option: SHIFT_U_SEQ_ROTATE_EN enables ROL for mode 11; without it
// mode 11 falls through to the SLL path (same word and same out-bit).
module shift_u_step
    import shift_u_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_word,
    output logic             out_bit
);

    always_comb begin
        next_word = word;
        out_bit   = 1'b0;
        case (mode)
            MODE_SRL: begin
                next_word = {1'b0, word[WIDTH-1:1]};
                out_bit   = word[0];
            end
            MODE_SRA: begin
                next_word = {word[WIDTH-1], word[WIDTH-1:1]};
                out_bit   = word[0];
            end
`ifdef SHIFT_U_SEQ_ROTATE_EN
            MODE_ROL: begin
                next_word = {word[WIDTH-2:0], word[WIDTH-1]};
                out_bit   = word[WIDTH-1];
            end
`endif
            // SLL, and mode 11 when rotate is not built
            default: begin
                next_word = {word[WIDTH-2:0], 1'b0};
                out_bit   = word[WIDTH-1];
            end
        endcase
    end

endmodule

// File: rtl/shift_u_seq.sv
// Purpose: sequential shift unit, one bit position per clock, START/READY command handshake.
// Latency: SHIFT_Flag in cycle k+SHAMT+1 after accept edge k (k+1 when SHAMT=0).
// Backpressure: READY low while shifting; START with READY low is dropped, never queued.
//
// Ports:
//   CLK          in  1        clock, rising edge
//   RST          in  1        synchronous active-high reset
//   START        in  1        command request, accepted when READY=1
//   SRC_SEL      in  1        0: shift IN1, 1: shift IN2
//   ALU_fun_SU   in  2        00 SRL, 01 SLL, 10 SRA, 11 ROL
//   SHAMT        in  SHAMT_W  shift amount 0..WIDTH-1
//   IN1, IN2     in  WIDTH    operands
//   READY        out 1        command can be accepted this cycle
//   SHIFT_Out    out WIDTH    working register; valid when SHIFT_Flag=1
//   SHIFT_Flag   out 1        one-cycle completion pulse
//   SHIFT_Carry  out 1        last bit shifted out; cleared on accept
//
// Build option: SHIFT_U_SEQ_ROTATE_EN (see shift_u_step) enables ROL.
module shift_u_seq
    import shift_u_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               SRC_SEL,
    input  logic [1:0]         ALU_fun_SU,
    input  logic [SHAMT_W-1:0] SHAMT,
    input  logic [WIDTH-1:0]   IN1,
    input  logic [WIDTH-1:0]   IN2,
    output logic               READY,
    output logic [WIDTH-1:0]   SHIFT_Out,
    output logic               SHIFT_Flag,
    output logic               SHIFT_Carry
);

    state_t             state;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   work;
    logic [1:0]         mode;
    logic               carry;

    logic [WIDTH-1:0]   step_word;
    logic               step_bit;

    shift_u_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .word      (work),
        .mode      (mode),
        .next_word (step_word),
        .out_bit   (step_bit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
            mode  <= MODE_SRL;
            carry <= 1'b0;
        end else begin
            case (state)
                // DONE accepts like IDLE so commands can run back-to-back
                IDLE, DONE: begin
                    if (START) begin
                        work  <= SRC_SEL ? IN2 : IN1;
                        mode  <= ALU_fun_SU;
                        cnt   <= SHAMT;
                        carry <= 1'b0;
                        state <= (SHAMT == '0) ? DONE : SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    work  <= step_word;
                    carry <= step_bit;
                    cnt   <= cnt - 1'b1;
                    // last step: the count of 1 is being consumed now
                    if (cnt == SHAMT_W'(1)) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers or a decode of state
    assign READY       = (state != SHIFT);
    assign SHIFT_Flag  = (state == DONE);
    assign SHIFT_Out   = work;
    assign SHIFT_Carry = carry;

endmodule
